// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, one-shot EXEC detour, and the IF/ID
// pipeline register with redirect squash and stall.
`ifndef ISIZE
`define ISIZE 16
`endif

module fetch_stage #(
  parameter int unsigned ISIZE = `ISIZE,
  parameter int unsigned PSIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PSIZE-1:0] imem_addr,
  input  logic [ISIZE-1:0] imem_data,
  input  logic             pc_sel,
  input  logic [PSIZE-1:0] pc_target,
  input  logic             pc_hold,
  input  logic             exec_req,
  input  logic [PSIZE-1:0] exec_addr,
  output logic [ISIZE-1:0] instr_id,
  output logic [PSIZE-1:0] pc1_id,
  output logic [ISIZE-1:0] last_instr,
  output logic             last_pcctrl,
  output logic             exec_active
);

  typedef enum logic {RUN = 1'b0, EXEC = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PSIZE-1:0] pc_q, pc_d;
  logic [PSIZE-1:0] ret_pc_q, ret_pc_d;
  logic [PSIZE-1:0] xaddr_q, xaddr_d;
  logic [ISIZE-1:0] instr_q, instr_d;
  logic [PSIZE-1:0] pc1_q, pc1_d;
  logic [ISIZE-1:0] last_q, last_d;
  logic             lpc_q, lpc_d;

  // State register; reset abandons any EXEC in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      pc_q     <= '0;
      ret_pc_q <= '0;
      xaddr_q  <= '0;
      instr_q  <= '0;
      pc1_q    <= '0;
      last_q   <= '0;
      lpc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ret_pc_q <= ret_pc_d;
      xaddr_q  <= xaddr_d;
      instr_q  <= instr_d;
      pc1_q    <= pc1_d;
      last_q   <= last_d;
      lpc_q    <= lpc_d;
    end
  end

  // Next-state: hold freezes everything; otherwise redirect beats EXEC entry
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ret_pc_d = ret_pc_q;
    xaddr_d  = xaddr_q;
    instr_d  = instr_q;
    pc1_d    = pc1_q;
    last_d   = last_q;
    lpc_d    = lpc_q;
    if (!pc_hold) begin
      last_d = instr_q;
      lpc_d  = pc_sel;
      case (state_q)
        RUN: begin
          if (pc_sel) begin
            pc_d    = pc_target;
            instr_d = '0;
            pc1_d   = '0;
          end else if (exec_req) begin
            ret_pc_d = pc_q;
            xaddr_d  = exec_addr;
            instr_d  = '0;
            state_d  = EXEC;
          end else begin
            instr_d = imem_data;
            pc1_d   = pc_q + PSIZE'(1);
            pc_d    = pc_q + PSIZE'(1);
          end
        end
        EXEC: begin
          state_d = RUN;
          if (pc_sel) begin
            pc_d    = pc_target;
            instr_d = '0;
            pc1_d   = '0;
          end else begin
            instr_d = imem_data;
            pc1_d   = ret_pc_q;
            pc_d    = ret_pc_q;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign imem_addr   = (state_q == EXEC) ? xaddr_q : pc_q;
  assign exec_active = (state_q == EXEC);
  assign instr_id    = instr_q;
  assign pc1_id      = pc1_q;
  assign last_instr  = last_q;
  assign last_pcctrl = lpc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset corner sequences, and
// randomized traffic against an abstract pipeline model.
module tb_fetch_stage;
  localparam int unsigned ISIZE = 16;
  localparam int unsigned PSIZE = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [PSIZE-1:0] imem_addr;
  logic [ISIZE-1:0] imem_data;
  logic             pc_sel, pc_hold, exec_req;
  logic [PSIZE-1:0] pc_target, exec_addr;
  logic [ISIZE-1:0] instr_id, last_instr;
  logic [PSIZE-1:0] pc1_id;
  logic             last_pcctrl, exec_active;

  fetch_stage #(.ISIZE(ISIZE), .PSIZE(PSIZE)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc_sel(pc_sel), .pc_target(pc_target), .pc_hold(pc_hold),
    .exec_req(exec_req), .exec_addr(exec_addr), .instr_id(instr_id),
    .pc1_id(pc1_id), .last_instr(last_instr), .last_pcctrl(last_pcctrl),
    .exec_active(exec_active)
  );

  always #5 clk = ~clk;

  // Instruction memory image: word at address a is a|0x1000
  assign imem_data = imem_addr | 16'h1000;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic        hold, sel, ex;
    logic [15:0] tgt, xa;
    logic [15:0] e_addr, e_instr, e_pc1, e_last;
    logic        e_lpc, e_ea;
  } vec_t;

  vec_t tbl[21];

  // Abstract model: ints, modulo arithmetic on the 16-bit address space
  int m_pc, m_ret, m_xaddr, m_instr, m_pc1, m_last, m_lpc;
  bit m_exec;

  function automatic int mem(input int a);
    return a | 32'h1000;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ret = 0; m_xaddr = 0; m_instr = 0; m_pc1 = 0;
    m_last = 0; m_lpc = 0; m_exec = 0;
  endtask

  task automatic model_step(input bit hold, input bit sel, input int tgt,
                            input bit ex, input int xa);
    if (hold) return;
    m_last = m_instr;
    m_lpc  = sel;
    if (sel) begin
      m_pc = tgt; m_instr = 0; m_pc1 = 0; m_exec = 0;
    end else if (m_exec) begin
      m_instr = mem(m_xaddr); m_pc1 = m_ret; m_pc = m_ret; m_exec = 0;
    end else if (ex) begin
      m_ret = m_pc; m_xaddr = xa; m_instr = 0; m_exec = 1;
    end else begin
      m_instr = mem(m_pc);
      m_pc    = (m_pc + 1) % 65536;
      m_pc1   = m_pc;
    end
  endtask

  task automatic drive(input logic h, input logic s, input logic [15:0] t,
                       input logic e, input logic [15:0] x);
    pc_hold = h; pc_sel = s; pc_target = t; exec_req = e; exec_addr = x;
  endtask

  task automatic check_all(input string tag, input logic [15:0] a, input logic [15:0] i,
                           input logic [15:0] p, input logic [15:0] l,
                           input logic lp, input logic ea);
    chk({tag, ".imem_addr"},   32'(imem_addr),   32'(a));
    chk({tag, ".instr_id"},    32'(instr_id),    32'(i));
    chk({tag, ".pc1_id"},      32'(pc1_id),      32'(p));
    chk({tag, ".last_instr"},  32'(last_instr),  32'(l));
    chk({tag, ".last_pcctrl"}, 32'(last_pcctrl), 32'(lp));
    chk({tag, ".exec_active"}, 32'(exec_active), 32'(ea));
  endtask

  initial begin
    //            hold sel ex   tgt       xa        addr      instr     pc1       last      lpc  ea
    tbl[0]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0001,16'h1000,16'h0001,16'h0000,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0002,16'h1001,16'h0002,16'h1000,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0003,16'h1002,16'h0003,16'h1001,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0004,16'h1003,16'h0004,16'h1002,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0005,16'h1004,16'h0005,16'h1003,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b0,16'h0040,16'h0000,16'h0040,16'h0000,16'h0000,16'h1004,1'b1,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0041,16'h1040,16'h0041,16'h0000,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b0,16'h0020,16'h0000,16'h0041,16'h1040,16'h0041,16'h0000,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b1,1'b0,16'h0020,16'h0000,16'h0041,16'h1040,16'h0041,16'h0000,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0,16'h0020,16'h0000,16'h0020,16'h0000,16'h0000,16'h1040,1'b1,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0021,16'h1020,16'h0021,16'h0000,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b0,16'h0010,16'h0000,16'h0010,16'h0000,16'h0000,16'h1020,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b1,16'h0000,16'h0080,16'h0080,16'h0000,16'h0000,16'h0000,1'b0,1'b1};
    tbl[13] = '{1'b0,1'b0,1'b1,16'h0000,16'h0090,16'h0010,16'h1080,16'h0010,16'h0000,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0011,16'h1010,16'h0011,16'h1080,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b1,16'h0000,16'h0030,16'h0030,16'h0000,16'h0011,16'h1010,1'b0,1'b1};
    tbl[16] = '{1'b1,1'b0,1'b0,16'h0000,16'h0000,16'h0030,16'h0000,16'h0011,16'h1010,1'b0,1'b1};
    tbl[17] = '{1'b0,1'b1,1'b0,16'h0050,16'h0000,16'h0050,16'h0000,16'h0000,16'h0000,1'b1,1'b0};
    tbl[18] = '{1'b0,1'b1,1'b1,16'hFFFF,16'h0077,16'hFFFF,16'h0000,16'h0000,16'h0000,1'b1,1'b0};
    tbl[19] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000,16'hFFFF,16'h0000,16'h0000,1'b0,1'b0};
    tbl[20] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0001,16'h1000,16'h0001,16'hFFFF,1'b0,1'b0};

    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    rst = 1'b0;
    #12;
    check_all("reset", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].hold, tbl[i].sel, tbl[i].tgt, tbl[i].ex, tbl[i].xa);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_instr, tbl[i].e_pc1,
                tbl[i].e_last, tbl[i].e_lpc, tbl[i].e_ea);
    end

    // Reset pulsed mid-EXEC: takes effect without a clock edge
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h0070);
    @(posedge clk); #1;
    chk("exec_enter.exec_active", 32'(exec_active), 32'(1));
    chk("exec_enter.imem_addr", 32'(imem_addr), 32'h70);
    #2 rst = 1'b0;
    #1;
    check_all("async_rst", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    @(posedge clk); #1;
    check_all("post_rst", 16'h1, 16'h1000, 16'h1, 16'h0, 1'b0, 1'b0);

    // Randomized traffic from a fresh reset
    rst = 1'b0; #1; rst = 1'b1;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      logic h, s, e;
      logic [15:0] t, x;
      h = ($urandom_range(0, 99) < 20);
      s = ($urandom_range(0, 99) < 20);
      e = ($urandom_range(0, 99) < 30);
      t = 16'($urandom);
      x = 16'($urandom);
      drive(h, s, t, e, x);
      @(posedge clk); #1;
      model_step(h, s, 32'(t), e, 32'(x));
      check_all($sformatf("rnd%0d", c),
                16'(m_exec ? m_xaddr : m_pc), 16'(m_instr), 16'(m_pc1),
                16'(m_last), 1'(m_lpc), m_exec);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_all($sformatf("rnd_rst%0d", c), 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
